// File: rtl/ps2_key_decoder_if.sv
// Key-event bus between the PS/2 byte receiver, the key decoder and the
// application logic. The decoder is the slave: it consumes scan-code bytes
// and pop requests, and presents the head of its key-event queue.
interface ps2_key_decoder_if;
    logic [7:0] PS2_code;
    logic       PS2_code_ready;
    logic       event_rd_en;
    logic       event_valid;
    logic [7:0] event_code;
    logic       event_extended;
    logic       event_break;
    logic       fifo_full;
    logic       overflow;
    logic       shift_held;

    modport slave (
        input  PS2_code,
        input  PS2_code_ready,
        input  event_rd_en,
        output event_valid,
        output event_code,
        output event_extended,
        output event_break,
        output fifo_full,
        output overflow,
        output shift_held
    );

    modport master (
        output PS2_code,
        output PS2_code_ready,
        output event_rd_en,
        input  event_valid,
        input  event_code,
        input  event_extended,
        input  event_break,
        input  fifo_full,
        input  overflow,
        input  shift_held
    );
endinterface

// File: rtl/ps2_key_decoder.sv
// PS/2 set-2 key decoder: turns raw scan-code bytes into key events
// (code, extended, make/break), queues them in a show-ahead FIFO and
// tracks whether either Shift key is currently held.
module ps2_key_decoder #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic              Clock_50,
    input  logic              Resetn,
    ps2_key_decoder_if.slave  bus
);

    localparam int ADDR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = ADDR_W + 1;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_EXT     = 3'd1;
    localparam logic [2:0] S_BRK     = 3'd2;
    localparam logic [2:0] S_EXT_BRK = 3'd3;
    localparam logic [2:0] S_SKIP    = 3'd4;

    logic              ready_q;
    logic              new_byte;
    logic [2:0]        state;
    logic [2:0]        state_next;
    logic [2:0]        skip_cnt;
    logic [2:0]        skip_next;
    logic              emit;
    logic              emit_ext;
    logic              emit_brk;
    logic [7:0]        byte_in;

    logic [7:0]        code_mem [FIFO_DEPTH];
    logic              ext_mem  [FIFO_DEPTH];
    logic              brk_mem  [FIFO_DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [CNT_W-1:0]  count;
    logic              full;
    logic              pop;
    logic              push_ok;
    logic              overflow_q;
    logic              shift_l;
    logic              shift_r;

    assign byte_in  = bus.PS2_code;
    assign new_byte = bus.PS2_code_ready & ~ready_q;
    assign full     = (count == CNT_W'(FIFO_DEPTH));
    assign pop      = bus.event_rd_en & (count != '0);
    assign push_ok  = emit & (~full | pop);

    // Register the ready level so each byte produces a single rising-edge strobe
    always_ff @(posedge Clock_50 or negedge Resetn) begin
        if (!Resetn) begin
            ready_q <= 1'b0;
        end else begin
            ready_q <= bus.PS2_code_ready;
        end
    end

    // Prefix decoding: decide the next state and whether this byte completes a key event
    always_comb begin
        state_next = state;
        skip_next  = skip_cnt;
        emit       = 1'b0;
        emit_ext   = 1'b0;
        emit_brk   = 1'b0;
        if (new_byte) begin
            case (state)
                S_IDLE: begin
                    case (byte_in)
                        8'hE0: state_next = S_EXT;
                        8'hF0: state_next = S_BRK;
                        8'hE1: begin
                            state_next = S_SKIP;
                            skip_next  = 3'd7;
                        end
                        8'h00, 8'hAA, 8'hEE, 8'hFA,
                        8'hFC, 8'hFE, 8'hFF: state_next = S_IDLE;
                        default: emit = 1'b1;
                    endcase
                end
                S_EXT: begin
                    case (byte_in)
                        8'hF0: state_next = S_EXT_BRK;
                        8'hE0: state_next = S_EXT;
                        8'h12: state_next = S_IDLE;
                        default: begin
                            emit       = 1'b1;
                            emit_ext   = 1'b1;
                            state_next = S_IDLE;
                        end
                    endcase
                end
                S_BRK: begin
                    state_next = S_IDLE;
                    if (byte_in != 8'hE0 && byte_in != 8'hE1 && byte_in != 8'hF0) begin
                        emit     = 1'b1;
                        emit_brk = 1'b1;
                    end
                end
                S_EXT_BRK: begin
                    state_next = S_IDLE;
                    if (byte_in != 8'h12 && byte_in != 8'hE0 &&
                        byte_in != 8'hE1 && byte_in != 8'hF0) begin
                        emit     = 1'b1;
                        emit_ext = 1'b1;
                        emit_brk = 1'b1;
                    end
                end
                S_SKIP: begin
                    skip_next = skip_cnt - 3'd1;
                    if (skip_cnt <= 3'd1) begin
                        skip_next  = 3'd0;
                        state_next = S_IDLE;
                    end
                end
                default: begin
                    state_next = S_IDLE;
                    skip_next  = 3'd0;
                end
            endcase
        end else if (state > S_SKIP) begin
            state_next = S_IDLE;
        end
    end

    // Prefix state and pause-sequence skip counter
    always_ff @(posedge Clock_50 or negedge Resetn) begin
        if (!Resetn) begin
            state    <= S_IDLE;
            skip_cnt <= 3'd0;
        end else begin
            state    <= state_next;
            skip_cnt <= skip_next;
        end
    end

    // Event queue: write on accepted push, advance head on pop, count tracks occupancy
    always_ff @(posedge Clock_50 or negedge Resetn) begin
        if (!Resetn) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                code_mem[i] <= 8'h00;
                ext_mem[i]  <= 1'b0;
                brk_mem[i]  <= 1'b0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                code_mem[wr_ptr] <= byte_in;
                ext_mem[wr_ptr]  <= emit_ext;
                brk_mem[wr_ptr]  <= emit_brk;
                wr_ptr           <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push_ok && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push_ok) begin
                count <= count - 1'b1;
            end
        end
    end

    // Sticky flag for events lost because the queue was full
    always_ff @(posedge Clock_50 or negedge Resetn) begin
        if (!Resetn) begin
            overflow_q <= 1'b0;
        end else if (emit && !push_ok) begin
            overflow_q <= 1'b1;
        end
    end

    // Shift tracking follows every decoded non-extended Shift event, even dropped ones
    always_ff @(posedge Clock_50 or negedge Resetn) begin
        if (!Resetn) begin
            shift_l <= 1'b0;
            shift_r <= 1'b0;
        end else if (emit && !emit_ext) begin
            if (byte_in == 8'h12) begin
                shift_l <= ~emit_brk;
            end
            if (byte_in == 8'h59) begin
                shift_r <= ~emit_brk;
            end
        end
    end

    assign bus.event_valid    = (count != '0);
    assign bus.event_code     = code_mem[rd_ptr];
    assign bus.event_extended = ext_mem[rd_ptr];
    assign bus.event_break    = brk_mem[rd_ptr];
    assign bus.fifo_full      = full;
    assign bus.overflow       = overflow_q;
    assign bus.shift_held     = shift_l | shift_r;

endmodule
